// File: rtl/ecc_pkg.sv
// Shared constants and the bit-position map for the Hamming SEC(38,32) code.
// Latency: n/a (package). Backpressure: n/a.
// Codeword layout: [37:32] check bits (check k at position 2^k), [31:0] data
// (data[0] at position 3 ... data[31] at position 38).
package ecc_pkg;

    localparam int ECC_DATA_W  = 32;
    localparam int ECC_CHK_W   = 6;
    localparam int ECC_CW_W    = 38;
    localparam int ECC_MAX_POS = 38;

    typedef logic [ECC_CW_W-1:0]  cw_t;
    typedef logic [ECC_CHK_W-1:0] syn_t;

    localparam syn_t ECC_MAX_SYN = syn_t'(ECC_MAX_POS);

    // Hamming position (1..38) of codeword bit idx. Check bits sit at the
    // powers of two; data bits fill the remaining positions in ascending order.
    // Only ever called with elaboration-time constants, so it folds away.
    function automatic syn_t bit_pos(input int idx);
        syn_t pos;
        int   n;
        pos = '0;
        n   = 0;
        if (idx >= ECC_DATA_W) begin
            pos = syn_t'(1 << (idx - ECC_DATA_W));
        end else begin
            for (int q = 3; q <= ECC_MAX_POS; q++) begin
                if ((q & (q - 1)) != 0) begin
                    if (n == idx) pos = syn_t'(q);
                    n++;
                end
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Hamming syndrome: XOR of the position indices of every set codeword bit.
// Latency: combinational. Backpressure: none.
// Ports: cw (38-bit codeword in), syn (6-bit syndrome out).
module ecc_syndrome
    import ecc_pkg::*;
(
    input  logic [ECC_CW_W-1:0]  cw,
    output logic [ECC_CHK_W-1:0] syn
);

    syn_t term [ECC_CW_W];

    for (genvar i = 0; i < ECC_CW_W; i++) begin : g_term
        assign term[i] = cw[i] ? bit_pos(i) : '0;
    end

    always_comb begin
        syn = '0;
        for (int i = 0; i < ECC_CW_W; i++) begin
            syn = syn ^ term[i];
        end
    end

endmodule

// File: rtl/ecc_sec_dec.sv
// Hamming SEC(38,32) decoder: corrects single-bit errors, flags syndromes 39..63.
// Latency: 2 cycles dec_vld_i -> dec_vld_o. Backpressure: none, one word per cycle.
// Ports: clk, rst (async active-high); dec_vld_i/dec_in in; dec_vld_o/dec_out,
//   dec_sec_err, dec_unc_err, dec_err_pos (raw syndrome) out; sec_cnt/unc_cnt
//   saturating error counters cleared by cnt_clr. Counters exist only when
//   ECC_DEC_CNT_EN is defined; otherwise they read 0 and cnt_clr is ignored.
module ecc_sec_dec
    import ecc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_vld_i,
    input  logic [ECC_CW_W-1:0]  dec_in,
    input  logic                 cnt_clr,
    output logic [ECC_CW_W-1:0]  dec_out,
    output logic                 dec_vld_o,
    output logic                 dec_sec_err,
    output logic                 dec_unc_err,
    output logic [ECC_CHK_W-1:0] dec_err_pos,
    output logic [7:0]           sec_cnt,
    output logic [7:0]           unc_cnt
);

    // ---------------- stage 1: syndrome + codeword ----------------
    syn_t syn_c;
    logic s1_vld;
    cw_t  s1_cw;
    syn_t s1_syn;

    ecc_syndrome u_syndrome (
        .cw  (dec_in),
        .syn (syn_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_cw  <= '0;
            s1_syn <= '0;
        end else begin
            s1_vld <= dec_vld_i;
            if (dec_vld_i) begin
                s1_cw  <= dec_in;
                s1_syn <= syn_c;
            end
        end
    end

    // ---------------- correction ----------------
    // At most one bit matches a syndrome in 1..38; 0 and 39..63 match nothing,
    // so those words pass through unmodified.
    cw_t  flip;
    cw_t  corr_cw;
    logic sec_c;
    logic unc_c;

    for (genvar i = 0; i < ECC_CW_W; i++) begin : g_flip
        assign flip[i] = (s1_syn == bit_pos(i));
    end

    assign corr_cw = s1_cw ^ flip;
    assign sec_c   = (s1_syn != '0) && (s1_syn <= ECC_MAX_SYN);
    assign unc_c   = (s1_syn > ECC_MAX_SYN);

    // ---------------- stage 2: corrected word + status ----------------
    // Word and syndrome hold across bubbles; the flags drop to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_vld_o   <= 1'b0;
            dec_out     <= '0;
            dec_err_pos <= '0;
            dec_sec_err <= 1'b0;
            dec_unc_err <= 1'b0;
        end else begin
            dec_vld_o <= s1_vld;
            if (s1_vld) begin
                dec_out     <= corr_cw;
                dec_err_pos <= s1_syn;
                dec_sec_err <= sec_c;
                dec_unc_err <= unc_c;
            end else begin
                dec_sec_err <= 1'b0;
                dec_unc_err <= 1'b0;
            end
        end
    end

    // ---------------- error counters ----------------
`ifdef ECC_DEC_CNT_EN
    // Counts follow the visible output, so they update the cycle after the
    // flagged word appears. Clear wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_cnt <= '0;
            unc_cnt <= '0;
        end else if (cnt_clr) begin
            sec_cnt <= '0;
            unc_cnt <= '0;
        end else begin
            if (dec_vld_o && dec_sec_err && (sec_cnt != 8'hFF))
                sec_cnt <= sec_cnt + 8'd1;
            if (dec_vld_o && dec_unc_err && (unc_cnt != 8'hFF))
                unc_cnt <= unc_cnt + 8'd1;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sec_cnt        = '0;
    assign unc_cnt        = '0;
`endif

endmodule

// File: tb/tb_ecc_sec_dec.sv
// Self-checking bench for ecc_sec_dec against a position-array reference model.
// Latency: n/a. Backpressure: n/a.
// Counter expectations follow ECC_DEC_CNT_EN (0 when the feature is absent).
module tb_ecc_sec_dec;

`ifdef ECC_DEC_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_vld_i = 1'b0;
    logic [37:0] dec_in = '0;
    logic        cnt_clr = 1'b0;
    logic [37:0] dec_out;
    logic        dec_vld_o;
    logic        dec_sec_err;
    logic        dec_unc_err;
    logic [5:0]  dec_err_pos;
    logic [7:0]  sec_cnt;
    logic [7:0]  unc_cnt;

    int errors = 0;
    int checks = 0;

    ecc_sec_dec dut (
        .clk         (clk),
        .rst         (rst),
        .dec_vld_i   (dec_vld_i),
        .dec_in      (dec_in),
        .cnt_clr     (cnt_clr),
        .dec_out     (dec_out),
        .dec_vld_o   (dec_vld_o),
        .dec_sec_err (dec_sec_err),
        .dec_unc_err (dec_unc_err),
        .dec_err_pos (dec_err_pos),
        .sec_cnt     (sec_cnt),
        .unc_cnt     (unc_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int pos_map [1:38];   // codeword bit index living at Hamming position p

    function automatic void build_map();
        int d;
        d = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) == 0) begin
                for (int k = 0; k < 6; k++) if ((1 << k) == p) pos_map[p] = 32 + k;
            end else begin
                pos_map[p] = d;
                d++;
            end
        end
    endfunction

    function automatic logic [5:0] ref_syn(input logic [37:0] cw);
        int s;
        s = 0;
        for (int p = 1; p <= 38; p++) if (cw[pos_map[p]]) s = s ^ p;
        return 6'(s);
    endfunction

    function automatic void ref_decode(input logic [37:0] cw, output logic [37:0] o,
                                       output logic [5:0] syn, output logic sec, output logic unc);
        syn = ref_syn(cw);
        o   = cw;
        sec = 1'b0;
        unc = 1'b0;
        if (syn >= 6'd1 && syn <= 6'd38) begin
            o[pos_map[int'(syn)]] = ~cw[pos_map[int'(syn)]];
            sec = 1'b1;
        end else if (syn > 6'd38) begin
            unc = 1'b1;
        end
    endfunction

    function automatic logic [37:0] encode(input logic [31:0] data);
        logic [37:0] cw;
        logic [5:0]  s;
        cw = {6'b0, data};
        s  = ref_syn(cw);
        cw[37:32] = s;
        return cw;
    endfunction

    // Expected visible outputs/counters, and the words presented so far.
    logic        m_vld, m_sec, m_unc;
    logic [37:0] m_out;
    logic [5:0]  m_pos;
    logic [7:0]  m_sec_cnt, m_unc_cnt;
    logic        hist_vld [$];
    logic [37:0] hist_dat [$];

    function automatic void model_reset();
        m_vld = 0; m_sec = 0; m_unc = 0; m_out = '0; m_pos = '0;
        m_sec_cnt = '0; m_unc_cnt = '0;
        hist_vld.delete();
        hist_dat.delete();
    endfunction

    // Present one cycle of input, advance the model across the edge, end at negedge.
    task automatic step(input logic vld, input logic [37:0] dat, input logic clr);
        logic [37:0] o;
        logic [5:0]  s;
        logic        se, ue;
        dec_vld_i = vld;
        dec_in    = dat;
        cnt_clr   = clr;
        @(posedge clk);
        if (CNT_EN) begin
            if (clr) begin
                m_sec_cnt = '0;
                m_unc_cnt = '0;
            end else begin
                if (m_vld && m_sec && m_sec_cnt != 8'hFF) m_sec_cnt = m_sec_cnt + 8'd1;
                if (m_vld && m_unc && m_unc_cnt != 8'hFF) m_unc_cnt = m_unc_cnt + 8'd1;
            end
        end
        hist_vld.push_back(vld);
        hist_dat.push_back(dat);
        if (hist_vld.size() > 2) begin
            void'(hist_vld.pop_front());
            void'(hist_dat.pop_front());
        end
        // Output now reflects the word presented two edges ago (hist[0] of 2).
        if (hist_vld.size() == 2 && hist_vld[0]) begin
            ref_decode(hist_dat[0], o, s, se, ue);
            m_vld = 1; m_out = o; m_pos = s; m_sec = se; m_unc = ue;
        end else begin
            m_vld = 0; m_sec = 0; m_unc = 0;
        end
        @(negedge clk);
    endtask

    function automatic logic [37:0] rand_cw();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[37:0];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        checks++;
        if ({dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos, sec_cnt, unc_cnt} !== 63'd0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%0b out=%h sec=%0b unc=%0b pos=%0d sc=%0d uc=%0d, want all 0",
                     dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos, sec_cnt, unc_cnt);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_directed();
        step(0, '0, 1);
        step(1, 38'h0, 0);
        checks++;
        if (dec_vld_o !== 1'b0) begin
            errors++; $display("FAIL latency_early: got vld_o=%0b, want 0 after 1 cycle", dec_vld_o);
        end
        step(0, '0, 0);
        checks++;
        if ({dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos} !== {1'b1, 38'h0, 1'b0, 1'b0, 6'd0}) begin
            errors++; $display("FAIL zero_word: got vld=%0b out=%h sec=%0b unc=%0b pos=%0d, want 1 0 0 0 0",
                               dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos);
        end
        step(1, 38'h00_0000_0001, 0);
        step(0, '0, 0);
        checks++;
        if ({dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos} !== {1'b1, 38'h0, 1'b1, 1'b0, 6'd3}) begin
            errors++; $display("FAIL data0_err: got vld=%0b out=%h sec=%0b unc=%0b pos=%0d, want 1 0 1 0 3",
                               dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos);
        end
        step(0, '0, 0);
        checks++;
        if ({dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos} !== {1'b0, 38'h0, 1'b0, 1'b0, 6'd3}) begin
            errors++; $display("FAIL bubble_hold: got vld=%0b out=%h sec=%0b unc=%0b pos=%0d, want 0 0 0 0 3",
                               dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos);
        end
        checks++;
        if (sec_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
            errors++; $display("FAIL sec_cnt_inc: got %0d, want %0d", sec_cnt, CNT_EN ? 1 : 0);
        end
        step(1, 38'h01_0000_0000, 0);
        step(0, '0, 0);
        checks++;
        if ({dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos} !== {1'b1, 38'h0, 1'b1, 1'b0, 6'd1}) begin
            errors++; $display("FAIL chk0_err: got vld=%0b out=%h sec=%0b unc=%0b pos=%0d, want 1 0 1 0 1",
                               dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos);
        end
        step(1, 38'h01_8000_0000, 0);
        step(0, '0, 0);
        checks++;
        if ({dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos} !==
            {1'b1, 38'h01_8000_0000, 1'b0, 1'b1, 6'd39}) begin
            errors++; $display("FAIL unc_word: got vld=%0b out=%h sec=%0b unc=%0b pos=%0d, want 1 0180000000 0 1 39",
                               dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos);
        end
        step(0, '0, 0);
        checks++;
        if ({sec_cnt, unc_cnt} !== (CNT_EN ? {8'd2, 8'd1} : 16'd0)) begin
            errors++; $display("FAIL cnt_after_unc: got sec=%0d unc=%0d, want %0d %0d",
                               sec_cnt, unc_cnt, CNT_EN ? 2 : 0, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_random();
        logic [37:0] w;
        int          a, b;
        for (int n = 0; n < 400; n++) begin
            w = encode($urandom());
            case ($urandom_range(0, 3))
                0: ;
                1: begin a = $urandom_range(0, 37); w[a] = ~w[a]; end
                2: begin
                    a = $urandom_range(0, 37);
                    b = (a + $urandom_range(1, 37)) % 38;
                    w[a] = ~w[a]; w[b] = ~w[b];
                end
                default: w = rand_cw();
            endcase
            step(($urandom % 4) != 0, w, ($urandom % 32) == 0);
            checks++;
            if ({dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos} !== {m_vld, m_out, m_sec, m_unc, m_pos}) begin
                errors++; $display("FAIL rand_out[%0d]: got %0b %h %0b %0b %0d, want %0b %h %0b %0b %0d", n,
                                   dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos,
                                   m_vld, m_out, m_sec, m_unc, m_pos);
            end
            checks++;
            if ({sec_cnt, unc_cnt} !== {m_sec_cnt, m_unc_cnt}) begin
                errors++; $display("FAIL rand_cnt[%0d]: got sec=%0d unc=%0d, want %0d %0d", n,
                                   sec_cnt, unc_cnt, m_sec_cnt, m_unc_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 14; n++) begin
            step(1, rand_cw(), 0);
            if (n >= 1) begin
                checks++;
                if (dec_vld_o !== 1'b1 || dec_out !== m_out || dec_err_pos !== m_pos) begin
                    errors++; $display("FAIL b2b[%0d]: got vld=%0b out=%h pos=%0d, want 1 %h %0d", n,
                                       dec_vld_o, dec_out, dec_err_pos, m_out, m_pos);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [37:0] w;
        step(0, '0, 1);
        for (int n = 0; n < 300; n++) begin
            w = encode($urandom());
            w[n % 38] = ~w[n % 38];
            step(1, w, 0);
        end
        step(0, '0, 0);
        step(0, '0, 0);
        step(0, '0, 0);
        checks++;
        if (sec_cnt !== (CNT_EN ? 8'hFF : 8'h00) || sec_cnt !== m_sec_cnt) begin
            errors++; $display("FAIL sec_sat: got %0d, want %0d", sec_cnt, CNT_EN ? 255 : 0);
        end
        step(0, '0, 1);
        step(1, 38'h00_0000_0001, 0);
        step(0, '0, 0);
        step(0, '0, 0);
        checks++;
        if (sec_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
            errors++; $display("FAIL sec_after_clr: got %0d, want %0d", sec_cnt, CNT_EN ? 1 : 0);
        end
        step(1, 38'h00_0000_0001, 0);
        step(0, '0, 0);      // flagged word visible now
        step(0, '0, 1);      // clear coincides with its increment
        checks++;
        if (sec_cnt !== 8'd0 || m_sec_cnt !== 8'd0) begin
            errors++; $display("FAIL clr_vs_inc: got %0d, want 0", sec_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        logic [37:0] w3;
        step(1, 38'h00_0000_0001, 0);
        dec_vld_i = 1;
        dec_in    = 38'h01_8000_0000;
        #2 rst = 1;
        #1;
        checks++;
        if ({dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos, sec_cnt, unc_cnt} !== 63'd0) begin
            errors++; $display("FAIL midreset_outputs: got vld=%0b out=%h sec=%0b unc=%0b pos=%0d sc=%0d uc=%0d, want all 0",
                               dec_vld_o, dec_out, dec_sec_err, dec_unc_err, dec_err_pos, sec_cnt, unc_cnt);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            step(0, '0, 0);
            checks++;
            if (dec_vld_o !== 1'b0) begin
                errors++; $display("FAIL midreset_ghost[%0d]: got vld_o=%0b, want 0", n, dec_vld_o);
            end
        end
        w3 = encode(32'hDEAD_BEEF);
        w3[7] = ~w3[7];
        step(1, w3, 0);
        step(0, '0, 0);
        checks++;
        if ({dec_vld_o, dec_out, dec_sec_err} !== {1'b1, encode(32'hDEAD_BEEF), 1'b1}) begin
            errors++; $display("FAIL midreset_first: got vld=%0b out=%h sec=%0b, want 1 %h 1",
                               dec_vld_o, dec_out, dec_sec_err, encode(32'hDEAD_BEEF));
        end
    endtask

    initial begin
        build_map();
        model_reset();
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_saturation();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
